// File: rtl/master_tx_ltssm.sv
// master_tx_ltssm
//   Transmit-side LTSSM companion. For the substate commanded by the main
//   LTSSM it selects the ordered set to transmit on all configured lanes,
//   handshakes each OS with the framer and counts completed OSes. It pulses
//   o_finish once the substate's minimum transmit count is reached. It also
//   owns TX electrical idle and the receiver-detect request.
//
//   Optional feature: define TX_SKP_INSERT_EN to insert one SKP ordered set
//   after every SKP_INTERVAL completed OSes while sending. When it is not
//   defined, o_osType is never SKP.
//
// Ports
//   clk                      clock
//   reset                    asynchronous, active-low reset
//   i_substate[3:0]          substate from the main LTSSM (0..9 valid)
//   i_numberOfDetectedLanes  lane count, legal values 1/2/4/8/16
//   i_osDone                 pulse: current OS finished on all enabled lanes
//   i_rxDetectDone           pulse: receiver detection complete
//   i_rxDetected             valid with i_rxDetectDone, 1 = receiver present
//   o_osValid                request to the framer to transmit o_osType
//   o_osType[2:0]            0 none, 1 TS1, 2 TS2, 3 IDL, 4 SKP
//   o_linkPad / o_lanePad    send PAD in the link / lane number field
//   o_laneEnable             thermometer mask of the detected lanes
//   o_txElecIdle             hold TX in electrical idle
//   o_rxDetectReq            request receiver detection
//   o_finish                 one-cycle pulse: TX requirement met
//   o_txDetectFail           registered detect result, valid with o_finish
module master_tx_ltssm #(
  parameter int MAXLANES          = 16,
  parameter int POLL_ACTIVE_COUNT = 1024,
  parameter int CFG_COUNT         = 16,
  parameter int SKP_INTERVAL      = 370
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          i_substate,
  input  logic [4:0]          i_numberOfDetectedLanes,
  input  logic                i_osDone,
  input  logic                i_rxDetectDone,
  input  logic                i_rxDetected,
  output logic                o_osValid,
  output logic [2:0]          o_osType,
  output logic                o_linkPad,
  output logic                o_lanePad,
  output logic [MAXLANES-1:0] o_laneEnable,
  output logic                o_txElecIdle,
  output logic                o_rxDetectReq,
  output logic                o_finish,
  output logic                o_txDetectFail
);

  typedef enum logic [1:0] {IDLE, SEND, DETECT, HOLD} state_t;

  localparam logic [2:0]  OS_NONE  = 3'd0;
  localparam logic [2:0]  OS_TS1   = 3'd1;
  localparam logic [2:0]  OS_TS2   = 3'd2;
  localparam logic [2:0]  OS_IDL   = 3'd3;
  localparam logic [10:0] CNT_MAX  = 11'h7FF;
  localparam logic [10:0] POLL_TGT = 11'(POLL_ACTIVE_COUNT);
  localparam logic [10:0] CFG_TGT  = 11'(CFG_COUNT);

  state_t              r_state;
  state_t              w_stateNxt;
  logic [3:0]          r_lastSub;
  logic [10:0]         r_count;
  logic                r_active;
  logic [2:0]          r_osType;
  logic                r_linkPad;
  logic                r_lanePad;
  logic [MAXLANES-1:0] r_laneEnable;
  logic                r_rxDetectReq;
  logic                r_finish;
  logic                r_txDetectFail;

  logic [10:0]         w_countNxt;
  logic                w_activeNxt;
  logic [2:0]          w_osTypeNxt;
  logic                w_linkPadNxt;
  logic                w_lanePadNxt;
  logic                w_rxDetectReqNxt;
  logic                w_finishNxt;
  logic                w_txDetectFailNxt;

  logic                w_subChange;
  logic                w_take;
  logic                w_abort;
  logic                w_load;
  logic                w_sending;
  logic                w_osDoneOk;
  logic                w_countEn;
  logic                w_countHit;
  logic [10:0]         w_countInc;
  logic [10:0]         w_target;
  logic                w_skpPending;
  logic [MAXLANES-1:0] w_laneMask;

  function automatic logic [2:0] os_type_of(input logic [3:0] s);
    case (s)
      4'd2, 4'd4, 4'd5, 4'd6, 4'd7: os_type_of = OS_TS1;
      4'd3, 4'd8:                   os_type_of = OS_TS2;
      4'd9:                         os_type_of = OS_IDL;
      default:                      os_type_of = OS_NONE;
    endcase
  endfunction

  // Thermometer mask; anything other than 1/2/4/8/16 (or wider than the
  // port) yields an empty mask, which also blocks transmission.
  function automatic logic [MAXLANES-1:0] lane_mask(input logic [4:0] n);
    logic [MAXLANES-1:0] m;
    m = '0;
    if ((n == 5'd1 || n == 5'd2 || n == 5'd4 || n == 5'd8 || n == 5'd16) &&
        int'(n) <= MAXLANES) begin
      for (int i = 0; i < MAXLANES; i++) begin
        if (i < int'(n)) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  assign w_laneMask  = lane_mask(i_numberOfDetectedLanes);
  assign w_subChange = (i_substate != r_lastSub);
  // Out-of-range substates are never taken, so lastSub keeps its old value.
  assign w_take      = (r_state == IDLE) && w_subChange && (i_substate <= 4'd9);
  // Any substate change while busy drops back to IDLE; the new substate is
  // then taken as a fresh request on the following cycle.
  assign w_abort     = (r_state != IDLE) && w_subChange;
  assign w_load      = w_take || w_abort;
  assign w_sending   = (r_state == SEND) || (r_state == HOLD);
  // An osDone racing a substate change belongs to the old sequence: drop it.
  assign w_osDoneOk  = w_sending && o_osValid && i_osDone && !w_subChange;
  assign w_countEn   = w_osDoneOk && !w_skpPending;
  assign w_countInc  = (r_count == CNT_MAX) ? CNT_MAX : r_count + 11'd1;
  assign w_target    = (r_lastSub == 4'd2) ? POLL_TGT : CFG_TGT;
  assign w_countHit  = (r_state == SEND) && w_countEn && (w_countInc == w_target);

`ifdef TX_SKP_INSERT_EN
  localparam logic [2:0] OS_SKP  = 3'd4;
  localparam logic [8:0] SKP_TGT = 9'(SKP_INTERVAL);

  logic [8:0] r_skpCnt;
  logic       r_skpPending;

  // The completion of a SKP clears the pending flag but is not counted,
  // neither toward the target nor toward the next SKP interval.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skpCnt     <= '0;
      r_skpPending <= 1'b0;
    end else if (w_load || !w_sending) begin
      r_skpCnt     <= '0;
      r_skpPending <= 1'b0;
    end else if (w_osDoneOk) begin
      if (r_skpPending) begin
        r_skpPending <= 1'b0;
      end else if (r_skpCnt + 9'd1 == SKP_TGT) begin
        r_skpCnt     <= '0;
        r_skpPending <= 1'b1;
      end else begin
        r_skpCnt     <= r_skpCnt + 9'd1;
      end
    end
  end

  assign w_skpPending = r_skpPending;
  assign o_osType     = r_skpPending ? OS_SKP : r_osType;
`else
  assign w_skpPending = 1'b0;
  assign o_osType     = r_osType;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_stateNxt;
  end

  // Next-state logic
  always_comb begin
    w_stateNxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_take) begin
          if (i_substate == 4'd0)      w_stateNxt = IDLE;
          else if (i_substate == 4'd1) w_stateNxt = DETECT;
          else                         w_stateNxt = SEND;
        end
      end
      DETECT: begin
        if (w_abort || i_rxDetectDone) w_stateNxt = IDLE;
      end
      SEND: begin
        if (w_abort)         w_stateNxt = IDLE;
        else if (w_countHit) w_stateNxt = HOLD;
      end
      HOLD: begin
        if (w_abort) w_stateNxt = IDLE;
      end
      default: w_stateNxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_activeNxt       = r_active;
    w_osTypeNxt       = r_osType;
    w_linkPadNxt      = r_linkPad;
    w_lanePadNxt      = r_lanePad;
    w_countNxt        = r_count;
    w_rxDetectReqNxt  = r_rxDetectReq;
    w_txDetectFailNxt = r_txDetectFail;
    w_finishNxt       = w_countHit;

    // The OS selection follows the incoming substate already on an abort,
    // so the framer switches type without a gap.
    if (w_load) begin
      w_activeNxt  = (i_substate >= 4'd2) && (i_substate <= 4'd9);
      w_osTypeNxt  = os_type_of(i_substate);
      w_linkPadNxt = (i_substate >= 4'd2) && (i_substate <= 4'd4);
      w_lanePadNxt = (i_substate >= 4'd2) && (i_substate <= 4'd5);
      w_countNxt   = '0;
    end else if (w_countEn) begin
      w_countNxt   = w_countInc;
    end

    if (w_take) begin
      w_rxDetectReqNxt = (i_substate == 4'd1);
      if (i_substate == 4'd0) w_finishNxt = 1'b1;
    end else if (r_state == DETECT) begin
      if (w_abort) begin
        w_rxDetectReqNxt  = 1'b0;
      end else if (i_rxDetectDone) begin
        w_rxDetectReqNxt  = 1'b0;
        w_txDetectFailNxt = !i_rxDetected;
        w_finishNxt       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lastSub      <= 4'hF;
      r_count        <= '0;
      r_active       <= 1'b0;
      r_osType       <= OS_NONE;
      r_linkPad      <= 1'b1;
      r_lanePad      <= 1'b1;
      r_laneEnable   <= '0;
      r_rxDetectReq  <= 1'b0;
      r_finish       <= 1'b0;
      r_txDetectFail <= 1'b0;
    end else begin
      if (w_take) r_lastSub <= i_substate;
      r_count        <= w_countNxt;
      r_active       <= w_activeNxt;
      r_osType       <= w_osTypeNxt;
      r_linkPad      <= w_linkPadNxt;
      r_lanePad      <= w_lanePadNxt;
      r_laneEnable   <= w_laneMask;
      r_rxDetectReq  <= w_rxDetectReqNxt;
      r_finish       <= w_finishNxt;
      r_txDetectFail <= w_txDetectFailNxt;
    end
  end

  assign o_osValid      = r_active && (r_laneEnable != '0);
  assign o_txElecIdle   = !r_active;
  assign o_linkPad      = r_linkPad;
  assign o_lanePad      = r_lanePad;
  assign o_laneEnable   = r_laneEnable;
  assign o_rxDetectReq  = r_rxDetectReq;
  assign o_finish       = r_finish;
  assign o_txDetectFail = r_txDetectFail;

endmodule

// File: tb/tb_master_tx_ltssm.sv
module tb_master_tx_ltssm;
`ifdef TX_SKP_INSERT_EN
  localparam int SKPI   = 4;
  localparam bit SKP_ON = 1'b1;
`else
  localparam int SKPI   = 370;
  localparam bit SKP_ON = 1'b0;
`endif
  localparam int ML = 16;

  logic          clk    = 1'b0;
  logic          reset  = 1'b0;
  logic [3:0]    sub    = 4'd0;
  logic [4:0]    lanes  = 5'd4;
  logic          osDone = 1'b0;
  logic          rxDone = 1'b0;
  logic          rxDet  = 1'b0;
  logic          o_osValid;
  logic [2:0]    o_osType;
  logic          o_linkPad;
  logic          o_lanePad;
  logic [ML-1:0] o_laneEnable;
  logic          o_txElecIdle;
  logic          o_rxDetectReq;
  logic          o_finish;
  logic          o_txDetectFail;

  master_tx_ltssm #(
    .MAXLANES(ML), .POLL_ACTIVE_COUNT(1024), .CFG_COUNT(16), .SKP_INTERVAL(SKPI)
  ) dut (
    .clk(clk), .reset(reset), .i_substate(sub), .i_numberOfDetectedLanes(lanes),
    .i_osDone(osDone), .i_rxDetectDone(rxDone), .i_rxDetected(rxDet),
    .o_osValid(o_osValid), .o_osType(o_osType), .o_linkPad(o_linkPad),
    .o_lanePad(o_lanePad), .o_laneEnable(o_laneEnable), .o_txElecIdle(o_txElecIdle),
    .o_rxDetectReq(o_rxDetectReq), .o_finish(o_finish), .o_txDetectFail(o_txDetectFail)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int n_fin  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Job: 0 waiting for a request, 1 detecting, 2 sending toward target,
  // 3 target met and still transmitting.
  logic [3:0]    m_ack    = 4'hF;
  int            m_job    = 0;
  bit            m_tx     = 0;
  logic [2:0]    m_type   = 3'd0;
  bit            m_lpad   = 1;
  bit            m_npad   = 1;
  logic [ML-1:0] m_lane   = '0;
  bit            m_rxReq  = 0;
  bit            m_fin    = 0;
  bit            m_fail   = 0;
  int            m_n      = 0;
  int            m_skpRun = 0;
  bit            m_skpNow = 0;

  function automatic logic [2:0] f_type(input int s);
    if (s == 2 || (s >= 4 && s <= 7)) return 3'd1;
    if (s == 3 || s == 8)             return 3'd2;
    if (s == 9)                       return 3'd3;
    return 3'd0;
  endfunction

  function automatic logic [ML-1:0] f_mask(input int n);
    logic [31:0] full;
    if (!(n == 1 || n == 2 || n == 4 || n == 8 || n == 16) || n > ML) return '0;
    full = (32'd1 << n) - 32'd1;
    return full[ML-1:0];
  endfunction

  task automatic m_select(input int s);
    m_tx     = (s >= 2 && s <= 9);
    m_type   = f_type(s);
    m_lpad   = (s >= 2 && s <= 4);
    m_npad   = (s >= 2 && s <= 5);
    m_n      = 0;
    m_skpRun = 0;
    m_skpNow = 0;
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_ack = 4'hF; m_job = 0; m_tx = 0; m_type = 3'd0; m_lpad = 1; m_npad = 1;
      m_lane = '0; m_rxReq = 0; m_fin = 0; m_fail = 0; m_n = 0;
      m_skpRun = 0; m_skpNow = 0;
    end else begin : step
      bit sent_ok;
      bit chg;
      sent_ok = m_tx && (m_lane != '0);
      chg     = (sub != m_ack);
      m_lane  = f_mask(int'(lanes));
      m_fin   = 0;
      if (m_job != 0 && chg) begin
        m_select(int'(sub));
        m_job   = 0;
        m_rxReq = 0;
      end else if (m_job == 0) begin
        if (chg && sub <= 4'd9) begin
          m_ack = sub;
          m_select(int'(sub));
          m_rxReq = (sub == 4'd1);
          if (sub == 4'd0)      m_fin = 1;
          else if (sub == 4'd1) m_job = 1;
          else                  m_job = 2;
        end
      end else if (m_job == 1) begin
        if (rxDone) begin
          m_rxReq = 0; m_fail = !rxDet; m_fin = 1; m_job = 0;
        end
      end else if (osDone && sent_ok) begin
        if (m_skpNow) m_skpNow = 0;
        else begin
          if (m_n < 2047) m_n++;
          if (m_job == 2 && m_n == ((m_ack == 4'd2) ? 1024 : 16)) begin
            m_fin = 1; m_job = 3;
          end
          if (SKP_ON) begin
            m_skpRun++;
            if (m_skpRun == SKPI) begin m_skpNow = 1; m_skpRun = 0; end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin : cmp
    logic [25:0] exp_v;
    logic [25:0] act_v;
    @(negedge clk);
    exp_v = {m_tx && (m_lane != '0), m_skpNow ? 3'd4 : m_type, m_lpad, m_npad,
             m_lane, !m_tx, m_rxReq, m_fin, m_fail};
    act_v = {o_osValid, o_osType, o_linkPad, o_lanePad, o_laneEnable,
             o_txElecIdle, o_rxDetectReq, o_finish, o_txDetectFail};
    checks++;
    if (act_v === exp_v) passes++;
    else $display("FAIL cycle@%0t: dut %h model %h", $time, act_v, exp_v);
    if (o_finish === 1'b1) n_fin++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(output logic fin);
    osDone = 1'b1;
    cyc();
    fin = o_finish;
    osDone = 1'b0;
    cyc();
  endtask

  // Pulses osDone until finish shows, bounded; returns the pulse count.
  task automatic until_finish(input int limit, output int np);
    logic f;
    np = 0;
    f  = 1'b0;
    while (!f && np < limit) begin
      pulse(f);
      np++;
    end
  endtask

  initial begin : main
    int   np;
    int   fin0;
    logic f;

    // Reset held, then released with detectQuiet
    cyc(); cyc();
    chk("rst_elecidle", o_txElecIdle, 1);
    chk("rst_osvalid", o_osValid, 0);
    chk("rst_pads", {o_linkPad, o_lanePad}, 2'b11);
    chk("rst_lanes", o_laneEnable, 0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("quiet_finish", o_finish, 1);
    chk("quiet_elecidle", o_txElecIdle, 1);
    cyc();
    chk("quiet_finish_one", o_finish, 0);
    chk("quiet_fin_count", n_fin, 1);

    // detectActive, receiver absent
    sub = 4'd1;
    cyc();
    chk("det_req", o_rxDetectReq, 1);
    cyc(); cyc();
    chk("det_req_hold", o_rxDetectReq, 1);
    rxDone = 1'b1; rxDet = 1'b0;
    cyc();
    rxDone = 1'b0;
    chk("det_finish", o_finish, 1);
    chk("det_fail", o_txDetectFail, 1);
    chk("det_req_drop", o_rxDetectReq, 0);
    cyc();

    // pollingActive on 4 lanes
    sub = 4'd2;
    cyc();
    chk("poll_valid", o_osValid, 1);
    chk("poll_type", o_osType, 1);
    chk("poll_pads", {o_linkPad, o_lanePad}, 2'b11);
    chk("poll_lanes", o_laneEnable, 32'h000F);
    chk("poll_elecidle", o_txElecIdle, 0);
    fin0 = n_fin;
    np = 0;
    f  = 1'b0;
    while (!f && np < 3000) begin
      if (np < 10) chk("poll_type_seq", o_osType, (SKP_ON && ((np + 1) % 5 == 0)) ? 4 : 1);
      pulse(f);
      np++;
    end
    chk("poll_pulses", np, SKP_ON ? 1279 : 1024);
    chk("poll_fin_count", n_fin, fin0 + 1);
    chk("poll_after_valid", o_osValid, 1);
    chk("poll_after_type", o_osType, SKP_ON ? 4 : 1);
    repeat (6) pulse(f);
    chk("poll_no_refinish", n_fin, fin0 + 1);

    // cfgComplete interrupted, then cfgIdle
    sub = 4'd8;
    cyc(); cyc();
    chk("cfgc_type", o_osType, 2);
    chk("cfgc_pads", {o_linkPad, o_lanePad}, 2'b00);
    fin0 = n_fin;
    repeat (15) pulse(f);
    sub = 4'd9;
    cyc(); cyc();
    chk("cfgc_aborted", n_fin, fin0);
    chk("idle_type", o_osType, 3);
    until_finish(40, np);
    chk("idle_pulses", np, SKP_ON ? 19 : 16);
    chk("idle_fin_count", n_fin, fin0 + 1);

    // Illegal lane count blocks transmission
    lanes = 5'd3;
    sub = 4'd4;
    cyc(); cyc();
    chk("bad_lanes", o_laneEnable, 0);
    chk("bad_valid", o_osValid, 0);
    chk("bad_linkpad", o_linkPad, 1);
    fin0 = n_fin;
    repeat (100) pulse(f);
    chk("bad_no_finish", n_fin, fin0);

    // osDone coinciding with a substate change is discarded
    lanes = 5'd4;
    sub = 4'd5;
    cyc(); cyc();
    repeat (3) pulse(f);
    sub = 4'd6; osDone = 1'b1;
    cyc();
    osDone = 1'b0;
    cyc();
    chk("lw_pads", {o_linkPad, o_lanePad}, 2'b00);
    fin0 = n_fin;
    until_finish(40, np);
    chk("lanenum_pulses", np, SKP_ON ? 19 : 16);
    chk("lanenum_fin_count", n_fin, fin0 + 1);

    // Out-of-range substate is ignored after the abort
    sub = 4'd12;
    cyc(); cyc(); cyc();
    chk("oor_valid", o_osValid, 0);
    chk("oor_elecidle", o_txElecIdle, 1);
    chk("oor_no_finish", n_fin, fin0 + 1);

    // Reset asserted mid-sequence
    sub = 4'd3;
    cyc(); cyc();
    chk("ts2_type", o_osType, 2);
    repeat (2) pulse(f);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", o_osValid, 0);
    chk("midrst_elecidle", o_txElecIdle, 1);
    chk("midrst_lanes", o_laneEnable, 0);
    chk("midrst_pads", {o_linkPad, o_lanePad}, 2'b11);
    cyc(); cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
